timing_generator: RTL and testbench

TIMING_GENERATOR -- requirements
Module: timing_generator

---
 rtl/timing_generator.sv | 111 +++++++++++
 tb/tb_timing_generator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/timing_generator.sv
// Beat sequencer for the instruction controller: one-hot T strobes,
// run/step/halt control and a completed-instruction counter.
module timing_generator (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        stop,
  input  logic [7:0]  IR,
  output logic [7:0]  T,
  output logic        running,
  output logic        halted,
  output logic        instr_done,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [2:0]  r_b;
  logic [2:0]  w_b_nx;
  logic        r_sm;
  logic        w_sm_nx;
  logic        r_stop_pend;
  logic        w_pend_nx;
  logic [15:0] r_count;

  logic [3:0]  w_op;
  logic        w_run;
  logic        w_long;
  logic        w_halt_dec;
  logic        w_last;
  logic        w_done;

  assign w_op       = IR[7:4];
  assign w_run      = (r_state == S_RUN);
  assign w_long     = (w_op == 4'b0100) || (w_op == 4'b0101);
  assign w_halt_dec = w_run && (r_b == 3'd3) && (w_op == 4'b0011);
  // Opcode is sampled on the beat itself to pick the final beat.
  assign w_last     = w_run && !w_halt_dec &&
                      (w_long ? (r_b == 3'd7) : (r_b == 3'd6));
  assign w_done     = w_last || w_halt_dec;

  always_comb begin
    w_state_nx = r_state;
    w_b_nx     = r_b;
    w_sm_nx    = r_sm;
    w_pend_nx  = r_stop_pend;
    unique case (r_state)
      S_RUN: begin
        w_pend_nx = r_stop_pend | stop;
        if (w_halt_dec) begin
          w_state_nx = S_HALTED;
          w_b_nx     = 3'd0;
          w_pend_nx  = 1'b0;
          w_sm_nx    = 1'b0;
        end else if (w_last) begin
          w_b_nx = 3'd0;
          if (r_stop_pend || r_sm) begin
            w_state_nx = S_IDLE;
            w_pend_nx  = 1'b0;
            w_sm_nx    = 1'b0;
          end
        end else begin
          w_b_nx = r_b + 3'd1;
        end
      end
      default: begin
        w_b_nx = 3'd0;
        if (start) begin
          w_state_nx = S_RUN;
          w_sm_nx    = 1'b0;
          w_pend_nx  = stop;
        end else if (step) begin
          w_state_nx = S_RUN;
          w_sm_nx    = 1'b1;
          w_pend_nx  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_b         <= 3'd0;
      r_sm        <= 1'b0;
      r_stop_pend <= 1'b0;
      r_count     <= 16'h0000;
    end else begin
      r_state     <= w_state_nx;
      r_b         <= w_b_nx;
      r_sm        <= w_sm_nx;
      r_stop_pend <= w_pend_nx;
      if (w_done)
        r_count <= r_count + 16'd1;
    end
  end

  assign T           = (w_run && !w_halt_dec) ? (8'd1 << r_b) : 8'h00;
  assign running     = w_run;
  assign halted      = (r_state == S_HALTED) || w_halt_dec;
  assign instr_done  = w_done;
  assign instr_count = r_count;

endmodule

// File: tb/tb_timing_generator.sv
// Directed and randomized checks of timing_generator against an
// instruction-level model of beat lengths and run/stop/halt behaviour.
module tb_timing_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        step;
  logic        stop;
  logic [7:0]  IR;
  logic [7:0]  T;
  logic        running;
  logic        halted;
  logic        instr_done;
  logic [15:0] instr_count;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'h0000;

  timing_generator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step       (step),
    .stop       (stop),
    .IR         (IR),
    .T          (T),
    .running    (running),
    .halted     (halted),
    .instr_done (instr_done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic ck(input string tag, input logic [15:0] got,
                    input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ck_all(input string tag, input logic [7:0] t,
                        input logic r, input logic h, input logic d);
    ck({tag, ".T"}, 16'(T), 16'(t));
    ck({tag, ".running"}, 16'(running), 16'(r));
    ck({tag, ".halted"}, 16'(halted), 16'(h));
    ck({tag, ".done"}, 16'(instr_done), 16'(d));
    ck({tag, ".count"}, instr_count, exp_cnt);
  endtask

  // Beats issued before completion (HALT: beats before its decode cycle).
  function automatic int blen(input logic [7:0] ir);
    case (ir[7:4])
      4'b0011:          return 3;
      4'b0100, 4'b0101: return 8;
      default:          return 7;
    endcase
  endfunction

  task automatic idle_cyc(input string tag, input logic h,
                          input logic s_start, input logic s_step,
                          input logic s_stop);
    @(negedge clk);
    start = s_start;
    step  = s_step;
    stop  = s_stop;
    #1;
    ck_all(tag, 8'h00, 1'b0, h, 1'b0);
  endtask

  // One instruction from beat 0; start/step are junk to show they are ignored.
  task automatic run_instr(input string tag, input logic [7:0] ir,
                           input int stop_at, output bit is_h);
    int n;
    n    = blen(ir);
    is_h = (ir[7:4] == 4'b0011);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      IR    = ir;
      start = 1'($urandom % 2);
      step  = 1'($urandom % 2);
      stop  = (k == stop_at);
      #1;
      ck_all(tag, 8'(1 << k), 1'b1, 1'b0, !is_h && (k == n - 1));
    end
    if (is_h) begin
      @(negedge clk);
      start = 1'($urandom % 2);
      step  = 1'($urandom % 2);
      stop  = 1'b0;
      #1;
      ck_all({tag, ".hdec"}, 8'h00, 1'b1, 1'b1, 1'b1);
    end
    exp_cnt = exp_cnt + 16'd1;
  endtask

  function automatic logic [7:0] rnd_ir();
    logic [3:0] op;
    case ($urandom % 4)
      0: op = 4'b0011;
      1: op = 4'b0100;
      2: op = 4'b0101;
      default: begin
        op = 4'($urandom);
        while (op == 4'b0011 || op == 4'b0100 || op == 4'b0101)
          op = 4'($urandom);
      end
    endcase
    return {op, 4'($urandom)};
  endfunction

  initial begin
    bit h;
    bit hs;
    bit sm;
    bit pend;
    int mode;
    int nins;
    int sa;
    logic [7:0] ir;

    rst   = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    stop  = 1'b0;
    IR    = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    ck_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // free run of ADDs, then stop mid-instruction
    idle_cyc("go_add", 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("add1", 8'h14, -1, hs);
    run_instr("add2", 8'h14, 2, hs);
    idle_cyc("after_stop", 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc("idle_stop", 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cyc("idle_still", 1'b0, 1'b0, 1'b0, 1'b0);

    // MUL length and continuation
    idle_cyc("go_mul", 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("mul1", 8'h40, -1, hs);
    run_instr("mul2", 8'h40, 0, hs);

    // HALT and resume
    idle_cyc("go_h", 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("pre_h", 8'h14, -1, hs);
    run_instr("halt", 8'h30, -1, hs);
    idle_cyc("halted", 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cyc("resume", 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr("post_h", 8'h14, 1, hs);

    // step mode, then start+step together
    idle_cyc("step", 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr("div_step", 8'h50, -1, hs);
    idle_cyc("after_step", 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc("start_step", 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr("ss1", 8'h14, -1, hs);
    run_instr("ss2", 8'h14, 3, hs);

    // start with stop: exactly one instruction
    idle_cyc("start_stop", 1'b0, 1'b1, 1'b0, 1'b1);
    run_instr("one", 8'h22, -1, hs);
    idle_cyc("after_one", 1'b0, 1'b0, 1'b0, 1'b0);

    // reset at beat 5 of a MUL
    idle_cyc("go_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      IR    = 8'h40;
      start = 1'b0;
      #1;
      ck_all("mul_pre", 8'(1 << k), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    ck_all("mul_b5", 8'h20, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0000;
    #1;
    ck_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);

    // counter wrap from 65535
    @(negedge clk);
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    exp_cnt = 16'hFFFF;
    idle_cyc("pre_wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr("wrap", 8'h14, -1, hs);
    idle_cyc("wrapped", 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized sessions
    h = 1'b0;
    repeat (25) begin
      mode = int'($urandom % 4);
      idle_cyc("rnd_go", h, mode != 1, mode == 1 || mode == 2, mode == 3);
      sm   = (mode == 1);
      pend = (mode == 3);
      nins = 0;
      h    = 1'b0;
      forever begin
        ir = rnd_ir();
        sa = -1;
        if (!sm && !pend && ($urandom % 3 == 0 || nins >= 4))
          sa = int'($urandom_range(0, blen(ir) - 2));
        run_instr("rnd", ir, sa, hs);
        nins++;
        if (hs) begin
          h = 1'b1;
          break;
        end
        if (sa >= 0)
          pend = 1'b1;
        if (pend || sm)
          break;
      end
    end
    idle_cyc("rnd_end", h, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
